// File: rtl/fft_pkg.sv
// Shared definitions for the 8-point FFT datapath: default widths, the complex
// sample type and the bit-reversal helper used by loader, core and benches.
package fft_pkg;

    localparam int DATA_W = 16;
    localparam int LOG2N  = 3;
    localparam int N      = 1 << LOG2N;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    // Reverses the low `width` bits of idx; upper bits of the result are zero.
    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int width);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < width; b++) begin
            r[width-1-b] = idx[b];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One N-entry complex register file: single synchronous write port, synchronous
// clear, and every entry readable in parallel.
module fft_frame_bank #(
    parameter  int DATA_W = fft_pkg::DATA_W,
    parameter  int N      = fft_pkg::N,
    localparam int AW     = $clog2(N)
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     we,
    input  logic [AW-1:0]            slot,
    input  logic signed [DATA_W-1:0] wr_re,
    input  logic signed [DATA_W-1:0] wr_im,
    output logic signed [DATA_W-1:0] rd_re [N],
    output logic signed [DATA_W-1:0] rd_im [N]
);

    logic signed [DATA_W-1:0] re_q [N];
    logic signed [DATA_W-1:0] re_d [N];
    logic signed [DATA_W-1:0] im_q [N];
    logic signed [DATA_W-1:0] im_d [N];

    always_comb begin
        // NOTE: every entry gets its hold value first, so no path infers a latch.
        re_d = re_q;
        im_d = im_q;
        if (clr) begin
            // NOTE: the storage is cleared on reset so the presented frame reads 0, not X.
            for (int i = 0; i < N; i++) begin
                re_d[i] = '0;
                im_d[i] = '0;
            end
        end else if (we) begin
            re_d[slot] = wr_re;
            im_d[slot] = wr_im;
        end
    end

    always_ff @(posedge clk) begin
        re_q <= re_d;
        im_q <= im_d;
    end

    assign rd_re = re_q;
    assign rd_im = im_q;

endmodule

// File: rtl/fft8_frame_loader.sv
// Serial-to-frame loader: writes samples into bit-reversed slots of a ping-pong
// bank pair and presents each complete frame until the consumer takes it.
module fft8_frame_loader #(
    parameter  int DATA_W = fft_pkg::DATA_W,
    parameter  int LOG2N  = fft_pkg::LOG2N,
    localparam int N      = 1 << LOG2N
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sof,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    output logic                     frame_valid,
    input  logic                     frame_ready,
    output logic signed [DATA_W-1:0] frame_re [N],
    output logic signed [DATA_W-1:0] frame_im [N],
    output logic                     frame_drop
);

    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
    logic [1:0]       full_cnt_q, full_cnt_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic             frame_drop_q, frame_drop_d;

    logic             accept;
    logic             take;
    logic             realign;
    logic             complete;
    logic [LOG2N-1:0] wr_slot;
    logic [1:0]       bank_we;

    logic signed [DATA_W-1:0] bank_re [2][N];
    logic signed [DATA_W-1:0] bank_im [2][N];

    // in_ready decodes only the occupancy register, keeping it off any input path.
    assign in_ready    = (full_cnt_q != 2'd2);
    assign frame_valid = (full_cnt_q != 2'd0);
    assign frame_drop  = frame_drop_q;

    always_comb begin
        accept   = in_valid && in_ready;
        take     = frame_valid && frame_ready;
        realign  = accept && in_sof && (wr_cnt_q != '0);
        complete = accept && !realign && (wr_cnt_q == LOG2N'(N - 1));
        wr_slot  = realign ? '0 : LOG2N'(fft_pkg::bitrev(32'(wr_cnt_q), LOG2N));

        wr_cnt_d = wr_cnt_q;
        if (accept) begin
            wr_cnt_d = realign ? LOG2N'(1) : wr_cnt_q + LOG2N'(1);
        end

        full_cnt_d = full_cnt_q;
        if (complete && !take) begin
            full_cnt_d = full_cnt_q + 2'd1;
        end else if (!complete && take) begin
            full_cnt_d = full_cnt_q - 2'd1;
        end

        wr_bank_d    = wr_bank_q ^ complete;
        rd_bank_d    = rd_bank_q ^ take;
        frame_drop_d = realign;
        bank_we[0]   = accept && !wr_bank_q;
        bank_we[1]   = accept && wr_bank_q;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment; all next-state math is in always_comb.
        if (rst) begin
            wr_cnt_q     <= '0;
            full_cnt_q   <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            frame_drop_q <= 1'b0;
        end else begin
            wr_cnt_q     <= wr_cnt_d;
            full_cnt_q   <= full_cnt_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            frame_drop_q <= frame_drop_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_frame_bank #(
            .DATA_W (DATA_W),
            .N      (N)
        ) u_bank (
            .clk   (clk),
            .clr   (rst),
            .we    (bank_we[b]),
            .slot  (wr_slot),
            .wr_re (in_re),
            .wr_im (in_im),
            .rd_re (bank_re[b]),
            .rd_im (bank_im[b])
        );
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            frame_re[i] = bank_re[rd_bank_q][i];
            frame_im[i] = bank_im[rd_bank_q][i];
        end
    end

endmodule

// File: tb/tb_fft8_frame_loader.sv
// Self-checking bench for fft8_frame_loader: a frame-queue reference model checked
// every cycle, a realignment vector table, directed corner sequences and random traffic.
module tb_fft8_frame_loader;
    import fft_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_sof;
    logic signed [15:0] in_re;
    logic signed [15:0] in_im;
    logic              frame_valid;
    logic              frame_ready;
    logic signed [15:0] frame_re [8];
    logic signed [15:0] frame_im [8];
    logic              frame_drop;

    fft8_frame_loader dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sof      (in_sof),
        .in_re       (in_re),
        .in_im       (in_im),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_re    (frame_re),
        .frame_im    (frame_im),
        .frame_drop  (frame_drop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int dut_takes = 0;

    // Position k of the input stream lands in slot_of[k].
    int slot_of [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    typedef struct {
        logic [15:0] re [8];
        logic [15:0] im [8];
    } frame_t;

    frame_t fq [$];
    cplx_t  pq [$];
    bit     m_drop = 1'b0;

    typedef struct {
        logic        v;
        logic        sof;
        logic        fr;
        logic [15:0] re;
        logic [15:0] im;
        logic        e_valid;
        logic        e_ready;
        logic        e_drop;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int  pre;
        bit  tk;
        bit  acc;
        frame_t f;
        if (rst) begin
            fq.delete();
            pq.delete();
            m_drop = 1'b0;
            return;
        end
        pre    = fq.size();
        tk     = (pre != 0) && frame_ready;
        acc    = in_valid && (pre != 2);
        m_drop = 1'b0;
        if (acc) begin
            if (in_sof && pq.size() != 0) begin
                pq.delete();
                m_drop = 1'b1;
            end
            pq.push_back('{re: in_re, im: in_im});
            if (pq.size() == 8) begin
                for (int k = 0; k < 8; k++) begin
                    f.re[slot_of[k]] = pq[k].re;
                    f.im[slot_of[k]] = pq[k].im;
                end
                fq.push_back(f);
                pq.delete();
            end
        end
        if (tk) void'(fq.pop_front());
    endtask

    task automatic compare();
        check("frame_valid", 16'(frame_valid), 16'(fq.size() != 0));
        check("in_ready", 16'(in_ready), 16'(fq.size() != 2));
        check("frame_drop", 16'(frame_drop), 16'(m_drop));
        if (fq.size() != 0) begin
            for (int s = 0; s < 8; s++) begin
                check($sformatf("frame_re[%0d]", s), frame_re[s], fq[0].re[s]);
                check($sformatf("frame_im[%0d]", s), frame_im[s], fq[0].im[s]);
            end
        end
    endtask

    task automatic cycle();
        if (frame_valid && frame_ready && !rst) dut_takes++;
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_sof = 1'b0;
        frame_ready = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    // Holds the sample on the bus until the model says it has been accepted.
    task automatic send(input logic [15:0] re, input logic [15:0] im, input logic sof);
        int waited = 0;
        in_valid = 1'b1;
        in_re = re;
        in_im = im;
        in_sof = sof;
        while (fq.size() == 2 && waited <= 50) begin
            cycle();
            waited++;
        end
        if (waited > 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: sample %h still stalled after %0d cycles", re, waited);
        end
        cycle();
        in_valid = 1'b0;
        in_sof = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_sf [8];
        exp_sf = '{16'd0, 16'd4, 16'd2, 16'd6, 16'd1, 16'd5, 16'd3, 16'd7};

        for (int i = 0; i < 11; i++) begin
            tbl[i] = '{v: 1'b1, sof: (i == 0 || i == 3), fr: 1'b0,
                       re: 16'(100 + i), im: 16'(200 + i),
                       e_valid: (i == 10), e_ready: 1'b1, e_drop: (i == 3)};
        end
        tbl[11] = '{v: 1'b0, sof: 1'b0, fr: 1'b0, re: 16'd0, im: 16'd0,
                    e_valid: 1'b1, e_ready: 1'b1, e_drop: 1'b0};
        tbl[12] = '{v: 1'b0, sof: 1'b0, fr: 1'b1, re: 16'd0, im: 16'd0,
                    e_valid: 1'b0, e_ready: 1'b1, e_drop: 1'b0};

        rst = 1'b1;
        in_valid = 1'b0;
        in_sof = 1'b0;
        in_re = '0;
        in_im = '0;
        frame_ready = 1'b0;

        // Reset state
        do_reset();
        for (int s = 0; s < 8; s++) begin
            check("reset_re", frame_re[s], 16'd0);
            check("reset_im", frame_im[s], 16'd0);
        end

        // Single frame, held
        for (int k = 0; k < 8; k++) send(16'(k), 16'(-k), k == 0);
        check("single_valid", 16'(frame_valid), 16'd1);
        for (int s = 0; s < 8; s++) begin
            check("single_re", frame_re[s], exp_sf[s]);
            check("single_im", frame_im[s], 16'(16'd0 - exp_sf[s]));
        end
        for (int h = 0; h < 4; h++) cycle();
        frame_ready = 1'b1;
        cycle();
        frame_ready = 1'b0;

        // Backpressure: two full banks, 17th sample stalls
        do_reset();
        for (int k = 0; k < 16; k++) send(16'(k), 16'(k + 100), 1'b0);
        check("bp_ready_low", 16'(in_ready), 16'd0);
        in_valid = 1'b1;
        in_re = 16'd16;
        in_im = 16'd116;
        for (int h = 0; h < 3; h++) cycle();
        check("bp_still_stalled", 16'(in_ready), 16'd0);
        frame_ready = 1'b1;
        cycle();
        frame_ready = 1'b0;
        check("bp_second_frame", frame_re[0], 16'd8);
        check("bp_ready_back", 16'(in_ready), 16'd1);
        cycle();
        in_valid = 1'b0;
        frame_ready = 1'b1;
        cycle();
        frame_ready = 1'b0;

        // Continuous streaming
        do_reset();
        frame_ready = 1'b1;
        dut_takes = 0;
        for (int k = 0; k < 64; k++) send(16'(k * 3), 16'(-k), k % 8 == 0);
        cycle();
        check("cont_frames", 16'(dut_takes), 16'd8);
        frame_ready = 1'b0;

        // Realignment via vector table
        do_reset();
        for (int i = 0; i < 13; i++) begin
            in_valid = tbl[i].v;
            in_sof = tbl[i].sof;
            in_re = tbl[i].re;
            in_im = tbl[i].im;
            frame_ready = tbl[i].fr;
            cycle();
            check($sformatf("tbl%0d_valid", i), 16'(frame_valid), 16'(tbl[i].e_valid));
            check($sformatf("tbl%0d_ready", i), 16'(in_ready), 16'(tbl[i].e_ready));
            check($sformatf("tbl%0d_drop", i), 16'(frame_drop), 16'(tbl[i].e_drop));
            if (i == 10) begin
                check("realign_slot0", frame_re[0], 16'd103);
                check("realign_slot4", frame_re[4], 16'd104);
            end
        end
        in_valid = 1'b0;
        in_sof = 1'b0;
        frame_ready = 1'b0;

        // Reset mid-operation overrides a same-cycle handshake
        do_reset();
        for (int k = 0; k < 13; k++) send(16'(k + 50), 16'(k + 60), 1'b0);
        in_valid = 1'b1;
        in_re = 16'h1234;
        in_im = 16'h5678;
        frame_ready = 1'b1;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        in_valid = 1'b0;
        frame_ready = 1'b0;
        check("rstmid_valid", 16'(frame_valid), 16'd0);
        check("rstmid_drop", 16'(frame_drop), 16'd0);
        for (int s = 0; s < 8; s++) begin
            check("rstmid_re", frame_re[s], 16'd0);
            check("rstmid_im", frame_im[s], 16'd0);
        end
        for (int k = 0; k < 8; k++) send(16'(k + 70), 16'(k + 80), 1'b0);
        check("rstmid_clean", frame_re[4], 16'd71);
        frame_ready = 1'b1;
        cycle();
        frame_ready = 1'b0;

        // Extremes
        do_reset();
        for (int k = 0; k < 8; k++) begin
            send((k % 2) ? 16'h7FFF : 16'h8000, (k % 2) ? 16'h8000 : 16'h7FFF, 1'b0);
        end
        check("ext_slot0_re", frame_re[0], 16'h8000);
        check("ext_slot4_re", frame_re[4], 16'h7FFF);
        check("ext_slot7_im", frame_im[7], 16'h8000);
        frame_ready = 1'b1;
        cycle();
        frame_ready = 1'b0;

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 500; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_sof = ($urandom_range(0, 15) == 0);
            in_re = 16'($urandom);
            in_im = 16'($urandom);
            frame_ready = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 149) == 0);
            cycle();
        end
        rst = 1'b0;
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
